// File: rtl/main_memory_mp.sv
// Multi-requester main memory: NUM_REQ requesters share a true dual-port RAM through a
// round-robin arbiter that grants up to two requests per cycle, after a hardware fill on reset.
module main_memory_mp #(
    parameter int                DATA_W     = 24,
    parameter int                ADDR_W     = 18,
    parameter int                DEPTH      = 2**ADDR_W,
    parameter int                NUM_REQ    = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_rdata,
    output logic [NUM_REQ-1:0]        rsp_err,
    output logic                      init_done
);

    localparam int               MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W     = MEM_AW + 1;
    localparam int               PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEPTH - 2);
    localparam logic [PTR_W:0]   NUM_REQ_L = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      init_active_s;
    logic                      run_s;
    logic [CNT_W-1:0]          init_cnt_r;
    logic [PTR_W-1:0]          rr_ptr_r;
    logic [PTR_W-1:0]          rr_ptr_nxt_s;
    logic [PTR_W:0]            scan_s;
    logic                      gnt_a_vld_s;
    logic                      gnt_b_vld_s;
    logic [PTR_W-1:0]          gnt_a_idx_s;
    logic [PTR_W-1:0]          gnt_b_idx_s;
    logic [ADDR_W-1:0]         addr_a_s;
    logic [ADDR_W-1:0]         addr_b_s;
    logic [DATA_W-1:0]         wdata_a_s;
    logic [DATA_W-1:0]         wdata_b_s;
    logic                      we_a_s;
    logic                      we_b_s;
    logic                      oor_a_s;
    logic                      oor_b_s;
    logic [MEM_AW-1:0]         mem_addr_a_s;
    logic [MEM_AW-1:0]         mem_addr_b_s;
    logic [DATA_W-1:0]         mem_wdata_a_s;
    logic [DATA_W-1:0]         mem_wdata_b_s;
    logic                      mem_we_a_s;
    logic                      mem_we_b_s;
    logic [DATA_W-1:0]         mem_rdata_a_s;
    logic [DATA_W-1:0]         mem_rdata_b_s;
    logic [NUM_REQ-1:0]        rsp_valid_r;
    logic [NUM_REQ-1:0]        rsp_valid_nxt_s;
    logic [NUM_REQ-1:0]        rsp_err_r;
    logic [NUM_REQ-1:0]        rsp_err_nxt_s;
    logic [NUM_REQ*DATA_W-1:0] rsp_rdata_r;
    logic [NUM_REQ*DATA_W-1:0] rsp_rdata_nxt_s;
    logic [DATA_W-1:0]         mem [0:DEPTH-1];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
        if (v == PTR_W'(NUM_REQ - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = v + PTR_W'(1);
        end
    endfunction

    function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
        addr_oor = ({1'b0, a} >= DEPTH_L);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: fill finishes when the last pair of words is written
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State decode
    always_comb begin
        init_active_s = 1'b0;
        run_s         = 1'b0;
        case (state_r)
            ST_INIT: init_active_s = 1'b1;
            ST_RUN:  run_s         = 1'b1;
            default: init_active_s = 1'b0;
        endcase
    end

    assign init_done = run_s;

    // Fill address counter, two words per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt_r <= '0;
        end else if (init_active_s) begin
            init_cnt_r <= init_cnt_r + CNT_W'(2);
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Round-robin scan from the pointer: first valid -> port A, second -> port B
    always_comb begin
        gnt_a_vld_s = 1'b0;
        gnt_b_vld_s = 1'b0;
        gnt_a_idx_s = '0;
        gnt_b_idx_s = '0;
        scan_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_s = {1'b0, rr_ptr_r} + (PTR_W + 1)'(k);
            if (scan_s >= NUM_REQ_L) begin
                scan_s = scan_s - NUM_REQ_L;
            end else begin
                scan_s = scan_s;
            end
            if (run_s && rst_n && req_valid[scan_s[PTR_W-1:0]]) begin
                if (!gnt_a_vld_s) begin
                    gnt_a_vld_s = 1'b1;
                    gnt_a_idx_s = scan_s[PTR_W-1:0];
                end else if (!gnt_b_vld_s) begin
                    gnt_b_vld_s = 1'b1;
                    gnt_b_idx_s = scan_s[PTR_W-1:0];
                end else begin
                    gnt_b_vld_s = 1'b1;
                end
            end else begin
                gnt_a_vld_s = gnt_a_vld_s;
            end
        end
    end

    // Pointer moves past the last granted requester
    always_comb begin
        if (gnt_b_vld_s) begin
            rr_ptr_nxt_s = ptr_inc(gnt_b_idx_s);
        end else if (gnt_a_vld_s) begin
            rr_ptr_nxt_s = ptr_inc(gnt_a_idx_s);
        end else begin
            rr_ptr_nxt_s = rr_ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Ready flags and per-port request selection
    always_comb begin
        req_ready = '0;
        addr_a_s  = '0;
        addr_b_s  = '0;
        wdata_a_s = '0;
        wdata_b_s = '0;
        we_a_s    = 1'b0;
        we_b_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_a_vld_s && (gnt_a_idx_s == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                addr_a_s     = req_addr[i*ADDR_W +: ADDR_W];
                wdata_a_s    = req_wdata[i*DATA_W +: DATA_W];
                we_a_s       = req_we[i];
            end else if (gnt_b_vld_s && (gnt_b_idx_s == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                addr_b_s     = req_addr[i*ADDR_W +: ADDR_W];
                wdata_b_s    = req_wdata[i*DATA_W +: DATA_W];
                we_b_s       = req_we[i];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
        oor_a_s = addr_oor(addr_a_s);
        oor_b_s = addr_oor(addr_b_s);
    end

    // RAM port drive: fill pattern during INIT, granted requests during RUN
    always_comb begin
        if (init_active_s) begin
            mem_addr_a_s  = init_cnt_r[MEM_AW-1:0];
            mem_addr_b_s  = init_cnt_r[MEM_AW-1:0] + MEM_AW'(1);
            mem_wdata_a_s = INIT_VALUE;
            mem_wdata_b_s = INIT_VALUE;
            mem_we_a_s    = rst_n;
            mem_we_b_s    = rst_n;
        end else begin
            mem_addr_a_s  = addr_a_s[MEM_AW-1:0];
            mem_addr_b_s  = addr_b_s[MEM_AW-1:0];
            mem_wdata_a_s = wdata_a_s;
            mem_wdata_b_s = wdata_b_s;
            mem_we_a_s    = gnt_a_vld_s && we_a_s && !oor_a_s;
            mem_we_b_s    = gnt_b_vld_s && we_b_s && !oor_b_s;
        end
    end

    // RAM write; port A is applied last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (mem_we_b_s) begin
            mem[mem_addr_b_s] <= mem_wdata_b_s;
        end
        if (mem_we_a_s) begin
            mem[mem_addr_a_s] <= mem_wdata_a_s;
        end
    end

    assign mem_rdata_a_s = mem[mem_addr_a_s];
    assign mem_rdata_b_s = mem[mem_addr_b_s];

    // Response routing back to the granted requesters (data sampled before the write)
    always_comb begin
        rsp_valid_nxt_s = '0;
        rsp_err_nxt_s   = '0;
        rsp_rdata_nxt_s = rsp_rdata_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_a_vld_s && (gnt_a_idx_s == PTR_W'(i))) begin
                rsp_valid_nxt_s[i] = !we_a_s;
                rsp_err_nxt_s[i]   = oor_a_s;
                if (!we_a_s) begin
                    rsp_rdata_nxt_s[i*DATA_W +: DATA_W] = oor_a_s ? INIT_VALUE : mem_rdata_a_s;
                end else begin
                    rsp_rdata_nxt_s[i*DATA_W +: DATA_W] = rsp_rdata_r[i*DATA_W +: DATA_W];
                end
            end else if (gnt_b_vld_s && (gnt_b_idx_s == PTR_W'(i))) begin
                rsp_valid_nxt_s[i] = !we_b_s;
                rsp_err_nxt_s[i]   = oor_b_s;
                if (!we_b_s) begin
                    rsp_rdata_nxt_s[i*DATA_W +: DATA_W] = oor_b_s ? INIT_VALUE : mem_rdata_b_s;
                end else begin
                    rsp_rdata_nxt_s[i*DATA_W +: DATA_W] = rsp_rdata_r[i*DATA_W +: DATA_W];
                end
            end else begin
                rsp_valid_nxt_s[i] = 1'b0;
                rsp_err_nxt_s[i]   = 1'b0;
            end
        end
    end

    // Response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_r <= '0;
            rsp_err_r   <= '0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
        end
    end

    // A reset arriving while a response is pending suppresses it immediately
    assign rsp_valid = rsp_valid_r & {NUM_REQ{rst_n}};
    assign rsp_err   = rsp_err_r & {NUM_REQ{rst_n}};
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_main_memory_mp.sv
// Self-checking bench for main_memory_mp: directed table, corner sequences and randomized
// traffic compared against a word-array reference model of the memory and arbiter.
module tb_main_memory_mp;

    localparam int          DW   = 24;
    localparam int          AW   = 18;
    localparam int          DEP  = 16;
    localparam int          NR   = 4;
    localparam logic [23:0] FILL = 24'hFFFFFF;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]  rsp_valid;
    logic [NR*DW-1:0] rsp_rdata;
    logic [NR-1:0]  rsp_err;
    logic           init_done;

    main_memory_mp #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_REQ(NR), .INIT_VALUE(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  v;
        logic [3:0]  we;
        logic [71:0] a;
        logic [95:0] d;
        logic [3:0]  rdy;
        logic [2:0]  cr;
        logic [23:0] cd;
    } vec_t;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [23:0] m_mem [DEP];
    int          m_p;
    logic [3:0]  m_rv;
    logic [3:0]  m_re;
    logic [23:0] m_rd [NR];
    vec_t        tbl [19];
    int          gcnt [NR];
    logic [3:0]  got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] v, input logic [3:0] we,
                                 input logic [17:0] a0, input logic [17:0] a1,
                                 input logic [17:0] a2, input logic [17:0] a3,
                                 input logic [23:0] d0, input logic [23:0] d1,
                                 input logic [23:0] d2, input logic [23:0] d3,
                                 input logic [3:0] rdy, input logic [2:0] cr,
                                 input logic [23:0] cd);
        vec_t r;
        r.v = v; r.we = we; r.a = {a3, a2, a1, a0}; r.d = {d3, d2, d1, d0};
        r.rdy = rdy; r.cr = cr; r.cd = cd;
        return r;
    endfunction

    function automatic logic [17:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic logic [23:0] wdata_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) m_mem[i] = FILL;
        for (int i = 0; i < NR; i++) m_rd[i] = 24'd0;
        m_p  = 0;
        m_rv = 4'b0000;
        m_re = 4'b0000;
    endtask

    // Release reset and count cycles until init_done, checking ready stays low meanwhile
    task automatic wait_init();
        int   n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        rst_n = 1'b1;
        while (n < 50) begin
            @(posedge clk); #1;
            n++;
            if (init_done) break;
            if (req_ready !== 4'b0000) bad = 1'b1;
        end
        req_valid = 4'b0000;
        chk("init_cycles", 64'(n), 64'd8);
        chk("ready_in_init", 64'(bad), 64'd0);
        model_reset();
    endtask

    // One bus cycle: check last responses and this cycle's grants, then advance the model
    task automatic cycle(input bit use_tbl, input logic [3:0] exp_rdy, input int chk_req,
                         input logic [23:0] chk_data, output logic [3:0] g_out);
        int          cand[$];
        int          ga;
        int          gb;
        int          g;
        logic [3:0]  eg;
        logic [3:0]  nv;
        logic [3:0]  ne;
        logic [17:0] a;
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        chk("rsp_err", 64'(rsp_err), 64'(m_re));
        for (int i = 0; i < NR; i++)
            chk($sformatf("rsp_rdata%0d", i), 64'(rsp_rdata[i*DW +: DW]), 64'(m_rd[i]));
        if (chk_req < NR) begin
            chk("tbl_rsp_valid", 64'(rsp_valid[chk_req]), 64'd1);
            chk("tbl_rsp_data", 64'(rsp_rdata[chk_req*DW +: DW]), 64'(chk_data));
        end
        for (int k = 0; k < NR; k++)
            if (req_valid[(m_p + k) % NR]) cand.push_back((m_p + k) % NR);
        ga = (cand.size() > 0) ? cand[0] : -1;
        gb = (cand.size() > 1) ? cand[1] : -1;
        eg = 4'b0000;
        if (ga >= 0) eg[ga] = 1'b1;
        if (gb >= 0) eg[gb] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        if (use_tbl) chk("tbl_req_ready", 64'(req_ready), 64'(exp_rdy));
        g_out = req_ready;
        nv = 4'b0000;
        ne = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            g = (s == 0) ? ga : gb;
            if (g >= 0) begin
                a = addr_of(g);
                if (a >= DEP) ne[g] = 1'b1;
                if (!req_we[g]) begin
                    nv[g]   = 1'b1;
                    m_rd[g] = (a >= DEP) ? FILL : m_mem[a[3:0]];
                end
            end
        end
        // second grantee's write first, so the first grantee's data survives a collision
        if (gb >= 0 && req_we[gb] && addr_of(gb) < DEP) m_mem[addr_of(gb)] = wdata_of(gb);
        if (ga >= 0 && req_we[ga] && addr_of(ga) < DEP) m_mem[addr_of(ga)] = wdata_of(ga);
        if (gb >= 0) m_p = (gb + 1) % NR;
        else if (ga >= 0) m_p = (ga + 1) % NR;
        m_rv = nv;
        m_re = ne;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mkv(4'b0001, 4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0001, 3'd4, 24'd0);
        tbl[1]  = mkv(4'b0001, 4'b0001, 18'd0, 18'd0, 18'd0, 18'd0, 24'd255, 24'd0, 24'd0, 24'd0, 4'b0001, 3'd0, FILL);
        tbl[2]  = mkv(4'b0001, 4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0001, 3'd4, 24'd0);
        tbl[3]  = mkv(4'b0010, 4'b0010, 18'd0, 18'd10, 18'd0, 18'd0, 24'd0, 24'd65535, 24'd0, 24'd0, 4'b0010, 3'd0, 24'd255);
        tbl[4]  = mkv(4'b0010, 4'b0000, 18'd0, 18'd10, 18'd0, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0010, 3'd4, 24'd0);
        tbl[5]  = mkv(4'b1100, 4'b0000, 18'd0, 18'd0, 18'd1, 18'd15, 24'd0, 24'd0, 24'd0, 24'd0, 4'b1100, 3'd1, 24'd65535);
        tbl[6]  = mkv(4'b1111, 4'b0000, 18'd2, 18'd3, 18'd4, 18'd6, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0011, 3'd3, FILL);
        tbl[7]  = mkv(4'b1111, 4'b0000, 18'd2, 18'd3, 18'd4, 18'd6, 24'd0, 24'd0, 24'd0, 24'd0, 4'b1100, 3'd4, 24'd0);
        tbl[8]  = mkv(4'b1111, 4'b0000, 18'd2, 18'd3, 18'd4, 18'd6, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0011, 3'd4, 24'd0);
        tbl[9]  = mkv(4'b1111, 4'b0000, 18'd2, 18'd3, 18'd4, 18'd6, 24'd0, 24'd0, 24'd0, 24'd0, 4'b1100, 3'd4, 24'd0);
        tbl[10] = mkv(4'b0001, 4'b0001, 18'd5, 18'd0, 18'd0, 18'd0, 24'd300, 24'd0, 24'd0, 24'd0, 4'b0001, 3'd4, 24'd0);
        tbl[11] = mkv(4'b0011, 4'b0001, 18'd5, 18'd5, 18'd0, 18'd0, 24'd3444, 24'd0, 24'd0, 24'd0, 4'b0011, 3'd4, 24'd0);
        tbl[12] = mkv(4'b0010, 4'b0000, 18'd0, 18'd5, 18'd0, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0010, 3'd1, 24'd300);
        tbl[13] = mkv(4'b0011, 4'b0011, 18'd7, 18'd7, 18'd0, 18'd0, 24'd90, 24'd1, 24'd0, 24'd0, 4'b0011, 3'd1, 24'd3444);
        tbl[14] = mkv(4'b1000, 4'b0000, 18'd0, 18'd0, 18'd0, 18'd7, 24'd0, 24'd0, 24'd0, 24'd0, 4'b1000, 3'd4, 24'd0);
        tbl[15] = mkv(4'b0100, 4'b0000, 18'd0, 18'd0, 18'd200000, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0100, 3'd3, 24'd90);
        tbl[16] = mkv(4'b1000, 4'b1000, 18'd0, 18'd0, 18'd0, 18'd16, 24'd0, 24'd0, 24'd0, 24'd5, 4'b1000, 3'd2, FILL);
        tbl[17] = mkv(4'b0001, 4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0001, 3'd4, 24'd0);
        tbl[18] = mkv(4'b0000, 4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 24'd0, 24'd0, 24'd0, 24'd0, 4'b0000, 3'd0, 24'd255);

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_we    = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata != '0), 64'd0);
        chk("reset_init_done", 64'(init_done), 64'd0);
        wait_init();

        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        for (int r = 0; r < 19; r++) begin
            req_valid = tbl[r].v;
            req_we    = tbl[r].we;
            req_addr  = tbl[r].a;
            req_wdata = tbl[r].d;
            cycle(1'b1, tbl[r].rdy, int'(tbl[r].cr), tbl[r].cd, got);
            if (r >= 6 && r <= 9)
                for (int i = 0; i < NR; i++) gcnt[i] += int'(got[i]);
        end
        for (int i = 0; i < NR; i++) chk($sformatf("grant_count%0d", i), 64'(gcnt[i]), 64'd2);

        // Random traffic; an ungranted request is held until accepted
        got = 4'b1111;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!(req_valid[i] && !got[i])) begin
                    req_valid[i]           = ($urandom_range(0, 99) < 60);
                    req_we[i]              = $urandom_range(0, 1) == 1;
                    req_addr[i*AW +: AW]   = 18'($urandom_range(0, 19));
                    req_wdata[i*DW +: DW]  = 24'($urandom());
                end
            end
            cycle(1'b0, 4'b0000, NR, 24'd0, got);
        end

        // Reset right after a read is accepted: its response must never appear
        req_valid = 4'b0001;
        req_we    = 4'b0000;
        req_addr  = 72'd3;
        cycle(1'b0, 4'b0000, NR, 24'd0, got);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("rst_mask_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata != '0), 64'd0);
        req_valid = 4'b1111;
        wait_init();

        req_valid = 4'b0001;
        req_we    = 4'b0000;
        req_addr  = 72'd5;
        cycle(1'b0, 4'b0000, NR, 24'd0, got);
        req_valid = 4'b0000;
        cycle(1'b0, 4'b0000, 0, FILL, got);
        cycle(1'b0, 4'b0000, NR, 24'd0, got);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
